serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-shares a single 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It captures operands on a start request, sequences the cell through WIDTH steps while holding the ripple carry in a register, then presents the registered sum and carry-out with a one-cycle done pulse. It is intended as a low-area adder for Mimas V2 designs where LUTs are scarcer than cycles.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 1..32)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request to begin an addition; sampled only when busy=0
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  single-cycle pulse: sum/cout valid
sum  output  WIDTH  registered result; holds until next accepted start completes
cout  output  1  registered final carry-out

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry reg=0, shift regs=0. Applies at any time, including mid-RUN; the in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE. Encoding is 2-bit binary: IDLE=0, RUN=1, DONE=2; code 3 is illegal and recovers to IDLE.
- IDLE: if start=1, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and go to RUN. Otherwise stay.
- RUN: the cell computes s=a_sh[0]^b_sh[0]^carry and co=majority(a_sh[0],b_sh[0],carry).
  - carry<=co; sum shift reg<={s, sum_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE and latch the final sum and cout<=co on the same edge.
- DONE: done=1 for exactly this one cycle; busy=0.
  - If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back operation) and the next state is RUN.
  - Otherwise the next state is IDLE.
- busy=1 iff state==RUN. done=1 iff state==DONE. Both are decoded from state registers.
- Latency: with start accepted at edge k, busy is high for cycles k+1..k+WIDTH, done is high in cycle k+WIDTH+1, and sum/cout are valid from that cycle onward.
- Throughput: one addition per WIDTH+1 cycles.
- start while busy=1 is ignored (not queued). a/b/cin changes after capture have no effect.
- sum and cout hold their last result through IDLE and through the next RUN. They update only at the RUN→DONE edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), which is exact.
- cnt width is clog2(WIDTH) (minimum 1). WIDTH=1 gives a single RUN cycle.

Decomposition:
- Shared include/package: state encodings ST_IDLE/ST_RUN/ST_DONE and the state width constant.
- One natural sub-module: fa_cell, a combinational 1-bit full adder (a, b, c → s, cout) instantiated once for the bit step.
- FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
1. Basic add: after reset, a=8'h25, b=8'h1A, cin=0, start pulse → busy high for 8 cycles, done pulse on cycle 9, sum=8'h3F, cout=0.
2. Carry ripple: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
3. Start while busy: start at k, second start with a=8'h01, b=8'h01 at k+3 → ignored. Result is that of the first operands, and exactly one done pulse occurs.
4. Back-to-back: start held high continuously with a=8'h10, b=8'h20 then a=8'h0F, b=8'h01 → done pulses 9 cycles apart, with results 8'h30 then 8'h10; no IDLE cycle between them.
5. Reset mid-op: rst_n=0 for 1 cycle at k+4 of a run → no done pulse, and busy=0, sum=0, cout=0 next cycle. A fresh start then produces a correct result.
6. WIDTH=1 instance: a=1, b=1, cin=1 → done 2 cycles after start, sum=1, cout=1. Also run a random 1000-op check of WIDTH=8 against a+b+cin.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared FSM encodings and sizing helper for the serial adder
package serial_add_ctrl_pkg;
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder shared across all bit steps
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder step per clock, LSB first
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_w(WIDTH);
    logic [ST_W-1:0]  state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry, s, co, last;
    fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .c(carry), .s(s), .cout(co));
    assign sum_nx = WIDTH'({s, sum_sh} >> 1);
    assign last   = cnt == CW'(WIDTH - 1);
    assign busy   = state == ST_RUN;
    assign done   = state == ST_DONE;
    // sequencer: capture on start, step the cell while running, latch result on the last step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry  <= co;
                    sum_sh <= sum_nx;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state <= ST_DONE;
                        sum   <= sum_nx;
                        cout  <= co;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for 8-bit and 1-bit serial adders
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;
    int         checks = 0, failures = 0;
    int         dones8 = 0, dones1 = 0, d0 = 0, n = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] e8;
    logic [1:0] e1;
    serial_add_ctrl #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_add_ctrl #(.WIDTH(1)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    // 8-bit result monitor: pop expected value on every done pulse
    always @(negedge clk) begin
        if (done8) begin
            dones8++;
            if (q8.size() == 0) check("sb8_empty", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                check("sum8", {23'd0, cout8, sum8}, {23'd0, e8});
            end
        end
    end
    // 1-bit result monitor
    always @(negedge clk) begin
        if (done1) begin
            dones1++;
            if (q1.size() == 0) check("sb1_empty", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("sum1", {30'd0, cout1, sum1}, {30'd0, e1});
            end
        end
    end
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        q8.push_back(9'(x) + 9'(y) + 9'(c));
        step;
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("busy8_run", busy8, 1);
            check("done8_run", done8, 0);
            step;
        end
        check("done8_pulse", done8, 1);
        check("busy8_done", busy8, 0);
        step;
        check("done8_single", done8, 0);
    endtask
    task automatic op1(input logic x, input logic y, input logic c);
        a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
        q1.push_back(2'(x) + 2'(y) + 2'(c));
        step;
        start1 = 1'b0;
        check("busy1_run", busy1, 1);
        step;
        check("done1_pulse", done1, 1);
        check("busy1_done", busy1, 0);
        step;
        check("done1_single", done1, 0);
    endtask
    initial begin
        step;
        step;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        rst_n = 1'b1;
        step;
        op8(8'h25, 8'h1A, 1'b0);
        check("t1_sum", sum8, 8'h3F);
        check("t1_cout", cout8, 0);
        op8(8'hFF, 8'h01, 1'b0);
        check("t2a", {cout8, sum8}, 9'h100);
        op8(8'hFF, 8'hFF, 1'b1);
        check("t2b", {cout8, sum8}, 9'h1FF);
        step;
        check("hold_idle", {cout8, sum8}, 9'h1FF);
        d0 = dones8;
        a8 = 8'h40; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
        q8.push_back(9'h074);
        step;
        start8 = 1'b0;
        step;
        step;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        step;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            step;
            n++;
        end
        check("ign_latency", n, 5);
        check("ign_sum", sum8, 8'h74);
        repeat (12) step;
        check("ign_one_done", dones8 - d0, 1);
        d0 = dones8;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        step;
        a8 = 8'h0F; b8 = 8'h01;
        q8.push_back(9'h010);
        repeat (8) step;
        check("b2b_done1", done8, 1);
        check("b2b_sum1", sum8, 8'h30);
        step;
        check("b2b_no_idle", busy8, 1);
        check("b2b_hold", sum8, 8'h30);
        repeat (8) step;
        check("b2b_done2", done8, 1);
        start8 = 1'b0;
        step;
        check("b2b_sum2", sum8, 8'h10);
        check("b2b_count", dones8 - d0, 2);
        a8 = 8'h77; b8 = 8'h88; cin8 = 1'b1; start8 = 1'b1;
        step;
        start8 = 1'b0;
        d0 = dones8;
        step;
        step;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        check("rstmid_busy", busy8, 0);
        check("rstmid_done", done8, 0);
        check("rstmid_sum", sum8, 0);
        check("rstmid_cout", cout8, 0);
        repeat (12) step;
        check("rstmid_no_done", dones8 - d0, 0);
        op8(8'hC8, 8'h64, 1'b1);
        check("rstmid_fresh", {cout8, sum8}, 9'h12D);
        op1(1'b1, 1'b1, 1'b1);
        check("w1_sum", sum1, 1);
        check("w1_cout", cout1, 1);
        for (int i = 0; i < 8; i++) op1(i[0], i[1], i[2]);
        repeat (1000) op8(8'($urandom), 8'($urandom), 1'($urandom));
        repeat (3) step;
        check("sb8_drain", q8.size(), 0);
        check("sb1_drain", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
